scan_debounce_4: RTL

- Sequencer that drives the 2-bit select of a 4:1 single-bit mux and samples the selected bit, which returns on sample_in.
- Debounces each of the 4 channels independently.
- Publishes a stable 4-bit vector plus per-channel rise/fall pulses to the processor's input logic, for example keypad or limit-switch lines of the unlock mechanism.

---
 rtl/scan_debounce_4.sv | 139 +++++++++++++
 1 files changed

// File: rtl/scan_debounce_4.sv
// Scans four lines through an external 4:1 mux, synchronizes the returned bit and
// debounces each channel into a stable vector with registered rise/fall/scan_done pulses.
module scan_debounce_4 #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_COUNT = 8,
    parameter int CNT_W          = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       sample_in,
    output logic [1:0] select,
    output logic [3:0] state_out,
    output logic [3:0] rise,
    output logic [3:0] fall,
    output logic       scan_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        SAMPLE  = 2'd2,
        ADVANCE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

    state_t                  state_r;
    state_t                  state_s;
    logic                    sync_meta_r;
    logic                    sync_q_r;
    logic [CNT_W-1:0]        settle_cnt_r;
    logic [CNT_W-1:0]        settle_cnt_s;
    logic [3:0][CNT_W-1:0]   cnt_r;
    logic [3:0][CNT_W-1:0]   cnt_s;
    logic [1:0]              select_s;
    logic [3:0]              state_out_s;
    logic [3:0]              rise_s;
    logic [3:0]              fall_s;
    logic                    scan_done_s;

    // Two-flop synchronizer on the mux return path.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_r <= 1'b0;
            sync_q_r    <= 1'b0;
        end else begin
            sync_meta_r <= sample_in;
            sync_q_r    <= sync_meta_r;
        end
    end

    // Next-state and next-output computation; pulses default low every cycle.
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        cnt_s        = cnt_r;
        select_s     = select;
        state_out_s  = state_out;
        rise_s       = 4'b0000;
        fall_s       = 4'b0000;
        scan_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                select_s = 2'd0;
                if (enable) begin
                    state_s      = SETTLE;
                    settle_cnt_s = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                settle_cnt_s = settle_cnt_r + CNT_ONE;
                if (settle_cnt_r == SETTLE_LAST) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = SETTLE;
                end
            end
            SAMPLE: begin
                state_s = ADVANCE;
                if (sync_q_r == state_out[select]) begin
                    cnt_s[select] = CNT_ZERO;
                end else if (cnt_r[select] == DEB_LAST) begin
                    state_out_s[select] = sync_q_r;
                    cnt_s[select]       = CNT_ZERO;
                    rise_s[select]      = sync_q_r;
                    fall_s[select]      = ~sync_q_r;
                end else begin
                    cnt_s[select] = cnt_r[select] + CNT_ONE;
                end
            end
            ADVANCE: begin
                select_s    = select + 2'd1;
                scan_done_s = (select == 2'd3);
                if (enable) begin
                    state_s      = SETTLE;
                    settle_cnt_s = CNT_ZERO;
                end else begin
                    // Leaving the scan abandons any partial debounce progress.
                    state_s  = IDLE;
                    select_s = 2'd0;
                    cnt_s    = {4{CNT_ZERO}};
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            settle_cnt_r <= CNT_ZERO;
            cnt_r        <= {4{CNT_ZERO}};
            select       <= 2'd0;
            state_out    <= 4'b0000;
            rise         <= 4'b0000;
            fall         <= 4'b0000;
            scan_done    <= 1'b0;
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
            cnt_r        <= cnt_s;
            select       <= select_s;
            state_out    <= state_out_s;
            rise         <= rise_s;
            fall         <= fall_s;
            scan_done    <= scan_done_s;
        end
    end

endmodule
